// File: rtl/sdram_req_queue.sv
// Client command FIFO in front of memory_controller: issues one req/ack transaction
// at a time, returns read data to the client, and bounds every wait with a timeout.
module sdram_req_queue #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_W      = 22,
    parameter int DATA_W      = 16,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic              clk_in,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [1:0]        cmd_be,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err,
    output logic              mc_req,
    output logic              mc_write,
    output logic [ADDR_W-1:0] mc_addr,
    output logic              mc_msb,
    output logic              mc_lsb,
    output logic [DATA_W-1:0] mc_wdata,
    output logic              mc_wdata_oe,
    input  logic [DATA_W-1:0] mc_rdata,
    input  logic              mc_ack,
    output logic              busy,
    output logic              err_timeout
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam int ENT_W = 1 + ADDR_W + DATA_W + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ENT_W-1:0]    fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                mc_req_q, mc_req_d, mc_write_q, mc_write_d;
    logic [ADDR_W-1:0]   mc_addr_q, mc_addr_d;
    logic                mc_msb_q, mc_msb_d, mc_lsb_q, mc_lsb_d;
    logic [DATA_W-1:0]   mc_wdata_q, mc_wdata_d;
    logic                rd_valid_q, rd_valid_d, rd_err_q, rd_err_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                err_timeout_q, err_timeout_d;
    logic                push, pop, ack_done, timed_out;

    // Client side is valid/ready: a command transfers on any edge where cmd_valid and
    // cmd_ready are both high; cmd_ready depends only on the registered count.
    assign cmd_ready = (count_q != CNT_W'(FIFO_DEPTH));
    assign push      = cmd_valid & cmd_ready;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        timer_d       = timer_q;
        mc_req_d      = 1'b0;
        mc_write_d    = mc_write_q;
        mc_addr_d     = mc_addr_q;
        mc_msb_d      = mc_msb_q;
        mc_lsb_d      = mc_lsb_q;
        mc_wdata_d    = mc_wdata_q;
        rd_valid_d    = 1'b0;
        rd_err_d      = 1'b0;
        rd_data_d     = rd_data_q;
        err_timeout_d = err_timeout_q;
        pop           = 1'b0;
        ack_done      = 1'b0;
        timed_out     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    {mc_write_d, mc_addr_d, mc_wdata_d, mc_msb_d, mc_lsb_d} = fifo_q[rd_ptr_q];
                    mc_req_d = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                if (mc_ack) begin
                    ack_done = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mc_ack) begin
                    ack_done = 1'b1;
                    state_d  = S_IDLE;
                    timer_d  = '0;
                end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    timed_out = 1'b1;
                    state_d   = S_IDLE;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ack_done && !mc_write_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mc_rdata;
        end
        // A timed-out read still owes the client a strobe, flagged and zeroed.
        if (timed_out) begin
            err_timeout_d = 1'b1;
            if (!mc_write_q) begin
                rd_valid_d = 1'b1;
                rd_err_d   = 1'b1;
                rd_data_d  = '0;
            end
        end

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk_in) begin
        if (push) fifo_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata, cmd_be};
    end

    always_ff @(posedge clk_in) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            timer_q       <= '0;
            mc_req_q      <= 1'b0;
            mc_write_q    <= 1'b0;
            mc_addr_q     <= '0;
            mc_msb_q      <= 1'b0;
            mc_lsb_q      <= 1'b0;
            mc_wdata_q    <= '0;
            rd_valid_q    <= 1'b0;
            rd_err_q      <= 1'b0;
            rd_data_q     <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            mc_req_q      <= mc_req_d;
            mc_write_q    <= mc_write_d;
            mc_addr_q     <= mc_addr_d;
            mc_msb_q      <= mc_msb_d;
            mc_lsb_q      <= mc_lsb_d;
            mc_wdata_q    <= mc_wdata_d;
            rd_valid_q    <= rd_valid_d;
            rd_err_q      <= rd_err_d;
            rd_data_q     <= rd_data_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign mc_req      = mc_req_q;
    assign mc_write    = mc_write_q;
    assign mc_addr     = mc_addr_q;
    assign mc_msb      = mc_msb_q;
    assign mc_lsb      = mc_lsb_q;
    assign mc_wdata    = mc_wdata_q;
    assign mc_wdata_oe = mc_write_q & (state_q != S_IDLE);
    assign rd_valid    = rd_valid_q;
    assign rd_err      = rd_err_q;
    assign rd_data     = rd_data_q;
    assign err_timeout = err_timeout_q;
    assign busy        = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_sdram_req_queue.sv
// Bench for sdram_req_queue: a controller model answers each mc_req with a chosen
// delay or no ack at all, and a scoreboard checks issue order, holding and read returns.
module tb_sdram_req_queue;
    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int T      = 64;
    localparam int CW     = 1 + ADDR_W + DATA_W + 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic [1:0]        cmd_be = '0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;
    logic              mc_req, mc_write, mc_msb, mc_lsb, mc_wdata_oe;
    logic [ADDR_W-1:0] mc_addr;
    logic [DATA_W-1:0] mc_wdata;
    logic [DATA_W-1:0] mc_rdata = '0;
    logic              mc_ack = 1'b0;
    logic              busy, err_timeout;

    always #5 clk = ~clk;

    sdram_req_queue #(
        .FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACK_TIMEOUT(T)
    ) dut (
        .clk_in(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .mc_req(mc_req), .mc_write(mc_write), .mc_addr(mc_addr),
        .mc_msb(mc_msb), .mc_lsb(mc_lsb), .mc_wdata(mc_wdata),
        .mc_wdata_oe(mc_wdata_oe), .mc_rdata(mc_rdata), .mc_ack(mc_ack),
        .busy(busy), .err_timeout(err_timeout)
    );

    int tests_run = 0;
    int fails = 0;

    // Scoreboard: commands in push order, and read returns in issue order.
    logic [CW-1:0]     exp_cmd_q[$];
    logic [DATA_W:0]   exp_rd_q[$];

    // Controller model state and knobs set by the stimulus.
    bit                outstanding = 0;
    int                k = 0;
    int                cur_d = 0;
    bit                cur_to = 0;
    logic [CW-1:0]     cur = '0;
    logic [DATA_W-1:0] cur_rdv = '0;
    logic [DATA_W:0]   rexp;
    bit                exp_err = 0;
    int                n_noack = 0;
    int                fix_delay = -1;
    int                fix_rdata = -1;
    bit                rand_to = 0;
    bit                stray_ack = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string msg);
        tests_run++;
        fails++;
        $display("FAIL %s: %s (t=%0t)", name, msg, $time);
    endtask

    task automatic check_hold();
        check("hold_cmd", 64'({mc_write, mc_addr, mc_wdata, mc_msb, mc_lsb}), 64'(cur));
        check("hold_oe", 64'(mc_wdata_oe), 64'(cur[CW-1]));
        check("hold_busy", 64'(busy), 64'(1));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 64'(cmd_ready), 64'(1));
        check({tag, "_zero"}, 64'({rd_valid, rd_data, rd_err, mc_req, mc_write, mc_addr,
                                   mc_msb, mc_lsb, mc_wdata, mc_wdata_oe, busy, err_timeout}),
              64'(0));
    endtask

    // Monitor + controller model, all on the falling edge.
    always @(negedge clk) begin
        mc_ack   = 1'b0;
        mc_rdata = DATA_W'($urandom);
        if (!rstn) begin
            outstanding = 0;
            exp_cmd_q.delete();
            exp_rd_q.delete();
            exp_err   = 0;
            stray_ack = 0;
        end else begin
            if (outstanding) begin
                k++;
                if (k == 1) check("req_pulse", 64'(mc_req), 64'(0));
                if (cur_to) begin
                    if (k < T) check_hold();
                    if (k == T + 1) begin
                        check("to_err_flag", 64'(err_timeout), 64'(1));
                        check("to_rd_strobe", 64'(rd_valid), 64'(!cur[CW-1]));
                        outstanding = 0;
                    end
                end else begin
                    if (k <= cur_d) check_hold();
                    if (k == cur_d) begin
                        mc_ack   = 1'b1;
                        mc_rdata = cur_rdv;
                    end
                    if (k == cur_d + 1) begin
                        check("ack_rd_strobe", 64'(rd_valid), 64'(!cur[CW-1]));
                        check("err_sticky", 64'(err_timeout), 64'(exp_err));
                        outstanding = 0;
                    end
                end
            end else if (stray_ack) begin
                mc_ack    = 1'b1;
                stray_ack = 0;
            end

            if (mc_req) begin
                if (outstanding) begin
                    fail_now("req_overlap", "mc_req while a command is outstanding");
                end else if (exp_cmd_q.size() == 0) begin
                    fail_now("req_unexpected", $sformatf("mc_req for addr 0x%0h", mc_addr));
                end else begin
                    cur         = exp_cmd_q.pop_front();
                    outstanding = 1;
                    k           = 0;
                    cur_to      = (n_noack > 0) || (rand_to && ($urandom_range(0, 15) == 0));
                    if (n_noack > 0) n_noack--;
                    cur_d   = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 5));
                    cur_rdv = (fix_rdata >= 0) ? DATA_W'(fix_rdata) : DATA_W'($urandom);
                    if (cur_to) exp_err = 1;
                    if (!cur[CW-1]) exp_rd_q.push_back(cur_to ? {1'b1, {DATA_W{1'b0}}} : {1'b0, cur_rdv});
                    check_hold();
                    if (!cur_to && cur_d == 0) begin
                        mc_ack   = 1'b1;
                        mc_rdata = cur_rdv;
                    end
                end
            end

            if (rd_valid) begin
                if (exp_rd_q.size() == 0) begin
                    fail_now("rd_unexpected", $sformatf("rd_valid with data 0x%0h err %0b", rd_data, rd_err));
                end else begin
                    rexp = exp_rd_q.pop_front();
                    check("rd_return", 64'({rd_err, rd_data}), 64'(rexp));
                end
            end
        end
    end

    task automatic push_cmd(input logic w, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic [1:0] be);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_be    = be;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            fail_now("push_stall", "cmd_ready never rose");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        exp_cmd_q.push_back({w, a, d, be});
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((busy || outstanding || exp_cmd_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 3000) fail_now("drain_timeout", "queue did not drain");
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        do_reset();
        check_reset_vals("rst");

        // Single read, ack four cycles after mc_req
        fix_delay = 4;
        fix_rdata = 16'hBEEF;
        push_cmd(1'b0, 22'h000002, 16'h0000, 2'b11);
        @(negedge clk);
        check("lat_edge_e", 64'(mc_req), 64'(0));
        @(negedge clk);
        check("lat_edge_e1", 64'(mc_req), 64'(1));
        wait_drain();
        check("t1_no_err", 64'(err_timeout), 64'(0));

        // Two writes back to back
        fix_delay = 2;
        fix_rdata = -1;
        push_cmd(1'b1, 22'h000101, 16'hAA55, 2'b11);
        push_cmd(1'b1, 22'h000102, 16'h1234, 2'b11);
        wait_drain();
        check("t2_rd_q_empty", 64'(exp_rd_q.size()), 64'(0));

        // Fill with the first command unacknowledged; sixth push stalls until it times out
        fix_delay = 1;
        n_noack   = 1;
        push_cmd(1'b0, 22'h000200, 16'h0000, 2'b01);
        for (int i = 1; i < 5; i++) push_cmd(i[0], ADDR_W'(32'h200 + i), DATA_W'(i * 3), 2'b10);
        @(negedge clk);
        check("full_ready_low", 64'(cmd_ready), 64'(0));
        repeat (5) @(negedge clk);
        check("full_ready_still_low", 64'(cmd_ready), 64'(0));
        push_cmd(1'b1, 22'h000205, 16'h5A5A, 2'b11);
        wait_drain();
        check("t3_err_sticky", 64'(err_timeout), 64'(1));

        // Read timeout followed by a queued write
        n_noack = 1;
        push_cmd(1'b0, 22'h000300, 16'h0000, 2'b11);
        push_cmd(1'b1, 22'h000301, 16'hC3C3, 2'b01);
        wait_drain();
        check("t4_err_sticky", 64'(err_timeout), 64'(1));

        // Reset while waiting with three commands queued, then a stray ack
        n_noack = 1;
        for (int i = 0; i < 4; i++) push_cmd(1'b0, ADDR_W'(32'h400 + i), 16'h0000, 2'b11);
        repeat (5) @(negedge clk);
        check("t5_pre_busy", 64'(busy), 64'(1));
        n_noack = 0;
        do_reset();
        check_reset_vals("mid_rst");
        stray_ack = 1;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("post_rst_quiet", 64'({rd_valid, mc_req, busy}), 64'(0));
        end

        // Randomized traffic with occasional missing acks
        fix_delay = -1;
        rand_to   = 1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push_cmd(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), 2'($urandom));
        end
        wait_drain();
        check("final_cmd_q_empty", 64'(exp_cmd_q.size()), 64'(0));
        check("final_rd_q_empty", 64'(exp_rd_q.size()), 64'(0));
        check("final_err", 64'(err_timeout), 64'(exp_err));

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #400000;
        fail_now("watchdog", "simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $fatal(1, "watchdog expired");
    end
endmodule
